gppcu_lane: RTL and testbench

GPPCU_LANE -- requirements
Module: gppcu_lane

---
 rtl/gppcu_lane.sv | 229 ++++++++++++++++++++++
 tb/tb_gppcu_lane.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_lane.sv
// Single GPPCU processing lane: register file, ALU, predicate flag, multi-cycle multiplier,
// and a local memory shared with the host.
module gppcu_lane #(
    parameter int DBW        = 32,
    parameter int ABW        = 10,
    parameter int NREG       = 16,
    parameter int MUL_CYCLES = 4,
    localparam int RB        = $clog2(NREG)
) (
    input  logic           iACLK,
    input  logic           iARESET,
    input  logic           iVALID,
    input  logic [3:0]     iOPC,
    input  logic           iPRED,
    input  logic [RB-1:0]  iRD,
    input  logic [RB-1:0]  iRS,
    input  logic [RB-1:0]  iRT,
    input  logic [DBW-1:0] iIMM,
    input  logic [DBW-1:0] iGMEMDATA,
    input  logic           iLMEMSEL,
    input  logic           iLMEMWREN,
    input  logic [ABW-1:0] iLMEMADDR,
    input  logic [DBW-1:0] iLMEMWDATA,
    output logic [DBW-1:0] oLMEMRDATA,
    output logic           oBUSY,
    output logic           oWB_VALID,
    output logic [DBW-1:0] oWB_DATA,
    output logic           oFLAG
);

    localparam int CW    = $clog2(MUL_CYCLES + 1);
    localparam int DEPTH = 1 << ABW;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_LDI   = 4'h7;
    localparam logic [3:0] OP_LDG   = 4'h8;
    localparam logic [3:0] OP_LDL   = 4'h9;
    localparam logic [3:0] OP_STL   = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_SETP  = 4'hC;
    localparam logic [3:0] OP_SETPZ = 4'hD;

    typedef enum logic {S_IDLE, S_RUN} mul_state_t;

    logic [DBW-1:0]        r_regs [NREG];
    logic [DBW-1:0]        r_lmem [DEPTH];
    logic                  r_flag;
    logic                  r_ld_busy;
    logic [RB-1:0]         r_ld_rd;
    logic [DBW-1:0]        r_ld_data;
    mul_state_t            r_mul_state, w_mul_state_nxt;
    logic [CW-1:0]         r_mul_cnt, w_mul_cnt_nxt;
    logic [DBW-1:0]        r_mul_a, r_mul_b;
    logic [RB-1:0]         r_mul_rd;
    logic                  r_wb_valid;
    logic [DBW-1:0]        r_wb_data;
    logic [DBW-1:0]        r_lmem_rdata;

    logic                  w_busy, w_accept, w_exec, w_mul_done;
    logic [DBW-1:0]        w_rs, w_rt, w_mul_lo;
    logic signed [DBW-1:0] w_rs_s, w_rt_s;
    logic [ABW-1:0]        w_lmem_addr;
    logic                  w_wr_en;
    logic [RB-1:0]         w_wr_rd;
    logic [DBW-1:0]        w_wr_data;

    assign w_busy      = iLMEMSEL | (r_mul_state == S_RUN) | r_ld_busy;
    assign w_accept    = iVALID & ~w_busy;
    // A squashed instruction is still consumed, it just has no side effects.
    assign w_exec      = w_accept & ~(iPRED & ~r_flag);
    assign w_rs        = (iRS == '0) ? '0 : r_regs[iRS];
    assign w_rt        = (iRT == '0) ? '0 : r_regs[iRT];
    assign w_rs_s      = w_rs;
    assign w_rt_s      = w_rt;
    assign w_lmem_addr = w_rs[ABW-1:0] + iIMM[ABW-1:0];
    assign w_mul_lo    = r_mul_a * r_mul_b;

    // Register-file write port; busy guarantees at most one source per edge.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_rd   = iRD;
        w_wr_data = '0;
        if (w_mul_done) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = r_mul_rd;
            w_wr_data = w_mul_lo;
        end else if (r_ld_busy) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = r_ld_rd;
            w_wr_data = r_ld_data;
        end else if (w_exec) begin
            w_wr_en = 1'b1;
            case (iOPC)
                OP_ADD:  w_wr_data = w_rs + w_rt;
                OP_SUB:  w_wr_data = w_rs - w_rt;
                OP_AND:  w_wr_data = w_rs & w_rt;
                OP_OR:   w_wr_data = w_rs | w_rt;
                OP_XOR:  w_wr_data = w_rs ^ w_rt;
                OP_SHL:  w_wr_data = w_rs << w_rt[4:0];
                OP_LDI:  w_wr_data = iIMM;
                OP_LDG:  w_wr_data = iGMEMDATA;
                default: w_wr_en   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr_en && w_wr_rd != '0) begin
            r_regs[w_wr_rd] <= w_wr_data;
        end
    end

    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            r_flag <= 1'b0;
        end else if (w_exec && iOPC == OP_SETP) begin
            r_flag <= (w_rs_s < w_rt_s);
        end else if (w_exec && iOPC == OP_SETPZ) begin
            r_flag <= (w_rs == '0);
        end
    end

    // Local memory is not reset; host has priority but never overlaps a lane store.
    always_ff @(posedge iACLK) begin
        if (iLMEMSEL && iLMEMWREN) begin
            r_lmem[iLMEMADDR] <= iLMEMWDATA;
        end else if (w_exec && iOPC == OP_STL) begin
            r_lmem[w_lmem_addr] <= w_rt;
        end
    end

    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            r_lmem_rdata <= '0;
        end else if (iLMEMSEL && !iLMEMWREN) begin
            r_lmem_rdata <= r_lmem[iLMEMADDR];
        end
    end

    // LDL captures the memory word at accept and retires it on the following edge.
    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            r_ld_busy <= 1'b0;
            r_ld_rd   <= '0;
            r_ld_data <= '0;
        end else if (w_exec && iOPC == OP_LDL) begin
            r_ld_busy <= 1'b1;
            r_ld_rd   <= iRD;
            r_ld_data <= r_lmem[w_lmem_addr];
        end else begin
            r_ld_busy <= 1'b0;
        end
    end

    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            r_mul_state <= S_IDLE;
            r_mul_cnt   <= '0;
        end else begin
            r_mul_state <= w_mul_state_nxt;
            r_mul_cnt   <= w_mul_cnt_nxt;
        end
    end

    always_comb begin
        w_mul_state_nxt = r_mul_state;
        w_mul_cnt_nxt   = r_mul_cnt;
        w_mul_done      = 1'b0;
        case (r_mul_state)
            S_IDLE: begin
                if (w_exec && iOPC == OP_MUL) begin
                    w_mul_state_nxt = S_RUN;
                    w_mul_cnt_nxt   = CW'(MUL_CYCLES - 1);
                end
            end
            S_RUN: begin
                if (r_mul_cnt == CW'(1)) begin
                    w_mul_done      = 1'b1;
                    w_mul_state_nxt = S_IDLE;
                    w_mul_cnt_nxt   = '0;
                end else begin
                    w_mul_cnt_nxt = r_mul_cnt - CW'(1);
                end
            end
            default: begin
                w_mul_state_nxt = S_IDLE;
                w_mul_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_mul_rd <= '0;
        end else if (w_exec && iOPC == OP_MUL) begin
            r_mul_a  <= w_rs;
            r_mul_b  <= w_rt;
            r_mul_rd <= iRD;
        end
    end

    always_ff @(posedge iACLK or posedge iARESET) begin
        if (iARESET) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
        end else if (w_wr_en && w_wr_rd != '0) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_wr_data;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    assign oBUSY      = w_busy;
    assign oWB_VALID  = r_wb_valid;
    assign oWB_DATA   = r_wb_data;
    assign oFLAG      = r_flag;
    assign oLMEMRDATA = r_lmem_rdata;

endmodule

// File: tb/tb_gppcu_lane.sv
// Directed testbench for gppcu_lane: ALU ops, MUL timing, host/lane memory,
// predication and mid-operation reset, each checked against hand-computed values.
module tb_gppcu_lane;

    logic        iACLK = 1'b0;
    logic        iARESET = 1'b1;
    logic        iVALID = 1'b0;
    logic [3:0]  iOPC = '0;
    logic        iPRED = 1'b0;
    logic [3:0]  iRD = '0, iRS = '0, iRT = '0;
    logic [31:0] iIMM = '0;
    logic [31:0] iGMEMDATA = 32'hDEAD_BEEF;
    logic        iLMEMSEL = 1'b0;
    logic        iLMEMWREN = 1'b0;
    logic [9:0]  iLMEMADDR = '0;
    logic [31:0] iLMEMWDATA = '0;
    logic [31:0] oLMEMRDATA;
    logic        oBUSY;
    logic        oWB_VALID;
    logic [31:0] oWB_DATA;
    logic        oFLAG;

    int n_total = 0;
    int n_bad   = 0;

    gppcu_lane dut (
        .iACLK(iACLK), .iARESET(iARESET), .iVALID(iVALID), .iOPC(iOPC), .iPRED(iPRED),
        .iRD(iRD), .iRS(iRS), .iRT(iRT), .iIMM(iIMM), .iGMEMDATA(iGMEMDATA),
        .iLMEMSEL(iLMEMSEL), .iLMEMWREN(iLMEMWREN), .iLMEMADDR(iLMEMADDR),
        .iLMEMWDATA(iLMEMWDATA), .oLMEMRDATA(oLMEMRDATA), .oBUSY(oBUSY),
        .oWB_VALID(oWB_VALID), .oWB_DATA(oWB_DATA), .oFLAG(oFLAG)
    );

    always #5 iACLK = ~iACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offer one instruction for exactly one edge; caller ensures the lane is idle.
    task automatic drive(input logic [3:0] opc, input logic pred, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [31:0] imm);
        iOPC = opc; iPRED = pred; iRD = rd; iRS = rs; iRT = rt; iIMM = imm; iVALID = 1'b1;
        @(posedge iACLK); #1;
        iVALID = 1'b0;
    endtask

    task automatic host_read(input logic [9:0] addr);
        iLMEMSEL = 1'b1; iLMEMWREN = 1'b0; iLMEMADDR = addr;
        @(posedge iACLK); #1;
        iLMEMSEL = 1'b0;
    endtask

    task automatic test_reset;
        iARESET = 1'b1;
        repeat (2) @(posedge iACLK);
        #1;
        n_total++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", oBUSY); end
        n_total++; if (oWB_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_wbv got=%b want=0", oWB_VALID); end
        n_total++; if (oWB_DATA !== 32'h0) begin n_bad++; $display("FAIL rst_wbd got=%h want=0", oWB_DATA); end
        n_total++; if (oFLAG !== 1'b0) begin n_bad++; $display("FAIL rst_flag got=%b want=0", oFLAG); end
        n_total++; if (oLMEMRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h want=0", oLMEMRDATA); end
        iARESET = 1'b0;
        @(posedge iACLK); #1;
    endtask

    task automatic test_alu;
        logic [3:0]  t_opc [13] = '{4'h7, 4'h7, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8,
                                    4'h7, 4'h6, 4'h7, 4'h1};
        logic [3:0]  t_rd  [13] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 0, 10};
        logic [3:0]  t_rs  [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0};
        logic [3:0]  t_rt  [13] = '{0, 0, 2, 2, 2, 2, 2, 2, 0, 0, 11, 0, 3};
        logic [31:0] t_imm [13] = '{5, 7, 0, 0, 0, 0, 0, 0, 0, 33, 0, 99, 0};
        logic [31:0] t_exp [13] = '{5, 7, 12, 32'hFFFF_FFFE, 5, 7, 2, 640, 32'hDEAD_BEEF,
                                    33, 10, 0, 12};
        logic        t_wbv [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 13; i++) begin
            drive(t_opc[i], 1'b0, t_rd[i], t_rs[i], t_rt[i], t_imm[i]);
            n_total++;
            if (oWB_VALID !== t_wbv[i] || (t_wbv[i] && oWB_DATA !== t_exp[i])) begin
                n_bad++;
                $display("FAIL alu_step%0d got vld=%b data=%h want vld=%b data=%h",
                         i, oWB_VALID, oWB_DATA, t_wbv[i], t_exp[i]);
            end
        end
        drive(4'h0, 1'b0, 4'd13, 4'd1, 4'd2, 32'd1);
        n_total++; if (oWB_VALID !== 1'b0) begin n_bad++; $display("FAIL nop_wbv got=%b want=0", oWB_VALID); end
        drive(4'hE, 1'b0, 4'd13, 4'd1, 4'd2, 32'd1);
        n_total++; if (oWB_VALID !== 1'b0) begin n_bad++; $display("FAIL opE_wbv got=%b want=0", oWB_VALID); end
    endtask

    task automatic test_mul;
        int busy_cnt;
        drive(4'h7, 1'b0, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF);
        drive(4'h7, 1'b0, 4'd2, 4'd0, 4'd0, 32'd2);
        iOPC = 4'hB; iPRED = 1'b0; iRD = 4'd4; iRS = 4'd1; iRT = 4'd2; iVALID = 1'b1;
        @(posedge iACLK); #1;
        iOPC = 4'h1; iRD = 4'd5; iRS = 4'd4; iRT = 4'd0;
        busy_cnt = 0;
        for (int i = 0; i < 10 && oBUSY === 1'b1; i++) begin
            busy_cnt++;
            n_total++;
            if (oWB_VALID !== 1'b0) begin
                n_bad++; $display("FAIL mul_early_wb cycle%0d got=%b want=0", i, oWB_VALID);
            end
            @(posedge iACLK); #1;
        end
        n_total++; if (busy_cnt != 3) begin n_bad++; $display("FAIL mul_busy_cycles got=%0d want=3", busy_cnt); end
        n_total++;
        if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL mul_result got vld=%b data=%h want vld=1 data=fffffffe", oWB_VALID, oWB_DATA);
        end
        @(posedge iACLK); #1;
        iVALID = 1'b0;
        n_total++;
        if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL mul_held_instr got vld=%b data=%h want vld=1 data=fffffffe", oWB_VALID, oWB_DATA);
        end
    endtask

    task automatic test_lmem;
        iLMEMSEL = 1'b1; iLMEMWREN = 1'b1; iLMEMADDR = 10'd1023; iLMEMWDATA = 32'hA5;
        #1;
        n_total++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL host_sel_busy got=%b want=1", oBUSY); end
        @(posedge iACLK); #1;
        iLMEMWREN = 1'b0;
        host_read(10'd1023);
        n_total++; if (oLMEMRDATA !== 32'hA5) begin n_bad++; $display("FAIL host_read got=%h want=a5", oLMEMRDATA); end
        iLMEMADDR = 10'd0;
        @(posedge iACLK); #1;
        n_total++; if (oLMEMRDATA !== 32'hA5) begin n_bad++; $display("FAIL host_read_hold got=%h want=a5", oLMEMRDATA); end
        drive(4'h9, 1'b0, 4'd5, 4'd0, 4'd0, 32'h7FF);
        n_total++;
        if (oBUSY !== 1'b1 || oWB_VALID !== 1'b0) begin
            n_bad++; $display("FAIL ldl_pending got busy=%b vld=%b want busy=1 vld=0", oBUSY, oWB_VALID);
        end
        @(posedge iACLK); #1;
        n_total++;
        if (oBUSY !== 1'b0 || oWB_VALID !== 1'b1 || oWB_DATA !== 32'hA5) begin
            n_bad++; $display("FAIL ldl_wrap got busy=%b vld=%b data=%h want busy=0 vld=1 data=a5",
                              oBUSY, oWB_VALID, oWB_DATA);
        end
        drive(4'h7, 1'b0, 4'd2, 4'd0, 4'd0, 32'h1234);
        drive(4'hA, 1'b0, 4'd0, 4'd0, 4'd2, 32'd5);
        n_total++; if (oWB_VALID !== 1'b0) begin n_bad++; $display("FAIL stl_wbv got=%b want=0", oWB_VALID); end
        host_read(10'd5);
        n_total++; if (oLMEMRDATA !== 32'h1234) begin n_bad++; $display("FAIL stl_mem got=%h want=1234", oLMEMRDATA); end
    endtask

    task automatic test_pred;
        drive(4'h7, 1'b0, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF);
        drive(4'h7, 1'b0, 4'd2, 4'd0, 4'd0, 32'd0);
        drive(4'h7, 1'b0, 4'd6, 4'd0, 4'd0, 32'd0);
        drive(4'hC, 1'b0, 4'd0, 4'd1, 4'd2, 32'd0);
        n_total++;
        if (oFLAG !== 1'b1 || oWB_VALID !== 1'b0) begin
            n_bad++; $display("FAIL setp_lt got flag=%b vld=%b want flag=1 vld=0", oFLAG, oWB_VALID);
        end
        drive(4'hC, 1'b0, 4'd0, 4'd2, 4'd1, 32'd0);
        n_total++; if (oFLAG !== 1'b0) begin n_bad++; $display("FAIL setp_signed got=%b want=0", oFLAG); end
        drive(4'hC, 1'b0, 4'd0, 4'd1, 4'd2, 32'd0);
        drive(4'hD, 1'b0, 4'd0, 4'd1, 4'd0, 32'd0);
        n_total++; if (oFLAG !== 1'b0) begin n_bad++; $display("FAIL setpz_nz got=%b want=0", oFLAG); end
        drive(4'h7, 1'b1, 4'd6, 4'd0, 4'd0, 32'd9);
        n_total++; if (oWB_VALID !== 1'b0) begin n_bad++; $display("FAIL pred_squash_wbv got=%b want=0", oWB_VALID); end
        drive(4'h1, 1'b0, 4'd7, 4'd6, 4'd0, 32'd0);
        n_total++;
        if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'd0) begin
            n_bad++; $display("FAIL pred_r6_zero got vld=%b data=%h want vld=1 data=0", oWB_VALID, oWB_DATA);
        end
        drive(4'hB, 1'b1, 4'd4, 4'd1, 4'd1, 32'd0);
        n_total++;
        if (oBUSY !== 1'b0 || oWB_VALID !== 1'b0) begin
            n_bad++; $display("FAIL pred_mul_squash got busy=%b vld=%b want busy=0 vld=0", oBUSY, oWB_VALID);
        end
        drive(4'hD, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
        n_total++; if (oFLAG !== 1'b1) begin n_bad++; $display("FAIL setpz_zero got=%b want=1", oFLAG); end
        drive(4'h7, 1'b1, 4'd6, 4'd0, 4'd0, 32'd9);
        n_total++;
        if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'd9) begin
            n_bad++; $display("FAIL pred_exec got vld=%b data=%h want vld=1 data=9", oWB_VALID, oWB_DATA);
        end
    endtask

    task automatic test_reset_mid_mul;
        drive(4'h7, 1'b0, 4'd1, 4'd0, 4'd0, 32'd3);
        drive(4'h7, 1'b0, 4'd2, 4'd0, 4'd0, 32'd4);
        drive(4'hB, 1'b0, 4'd4, 4'd1, 4'd2, 32'd0);
        @(posedge iACLK); #1;
        n_total++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL mid_mul_busy got=%b want=1", oBUSY); end
        iARESET = 1'b1;
        #1;
        n_total++;
        if (oBUSY !== 1'b0 || oFLAG !== 1'b0 || oWB_VALID !== 1'b0 || oWB_DATA !== 32'd0) begin
            n_bad++; $display("FAIL async_rst got busy=%b flag=%b vld=%b data=%h want all 0",
                              oBUSY, oFLAG, oWB_VALID, oWB_DATA);
        end
        @(posedge iACLK); #1;
        iARESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge iACLK); #1;
            n_total++;
            if (oWB_VALID !== 1'b0 || oBUSY !== 1'b0) begin
                n_bad++; $display("FAIL rst_abort cycle%0d got vld=%b busy=%b want 0 0", i, oWB_VALID, oBUSY);
            end
        end
        drive(4'h1, 1'b0, 4'd8, 4'd4, 4'd0, 32'd0);
        n_total++;
        if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'd0) begin
            n_bad++; $display("FAIL rst_r4 got vld=%b data=%h want vld=1 data=0", oWB_VALID, oWB_DATA);
        end
        drive(4'h1, 1'b0, 4'd9, 4'd1, 4'd2, 32'd0);
        n_total++;
        if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'd0) begin
            n_bad++; $display("FAIL rst_r1_r2 got vld=%b data=%h want vld=1 data=0", oWB_VALID, oWB_DATA);
        end
        host_read(10'd1023);
        n_total++; if (oLMEMRDATA !== 32'hA5) begin n_bad++; $display("FAIL rst_lmem_keep got=%h want=a5", oLMEMRDATA); end
        host_read(10'd5);
        n_total++; if (oLMEMRDATA !== 32'h1234) begin n_bad++; $display("FAIL rst_lmem_keep5 got=%h want=1234", oLMEMRDATA); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mul;
        test_lmem;
        test_pred;
        test_reset_mid_mul;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
